// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, special register IDs and widths.
package y86_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREGS  = 15;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/write_back_regfile.sv
// Architectural register file: 15 entries, two write ports (M wins on a
// shared destination), two combinational read ports, async active-low clear.
module write_back_regfile
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        dste_i,
  input  logic [3:0]        dstm_i,
  input  logic [DATA_W-1:0] vale_i,
  input  logic [DATA_W-1:0] valm_i,
  input  logic [3:0]        srca_i,
  input  logic [3:0]        srcb_i,
  output logic [DATA_W-1:0] vala_o,
  output logic [DATA_W-1:0] valb_o
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Next-state: E port first, M port overrides so it wins on a shared ID.
  // ID 0xF never matches any index, so RNONE writes nothing.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (dste_i == 4'(i)) regs_d[i] = vale_i;
      if (dstm_i == 4'(i)) regs_d[i] = valm_i;
    end
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: no write bypass; ID 0xF reads as zero.
  always_comb begin
    vala_o = '0;
    valb_o = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (srca_i == 4'(i)) vala_o = regs_q[i];
      if (srcb_i == 4'(i)) valb_o = regs_q[i];
    end
  end

endmodule

// File: rtl/write_back.sv
// SEQ write-back stage: decodes E/M destinations and commits into the regfile.
module write_back
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        icode_i,
  input  logic [3:0]        ra_i,
  input  logic [3:0]        rb_i,
  input  logic [DATA_W-1:0] vale_i,
  input  logic [DATA_W-1:0] valm_i,
  input  logic [3:0]        srca_i,
  input  logic [3:0]        srcb_i,
  output logic [DATA_W-1:0] vala_o,
  output logic [DATA_W-1:0] valb_o,
  output logic [3:0]        dste_o,
  output logic [3:0]        dstm_o
);

  // Destination decode; unknown or unrecognised icodes select no register.
  always_comb begin
    dste_o = RNONE;
    dstm_o = RNONE;
    case (icode_i)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:        dste_o = rb_i;
      I_CALL, I_RET, I_PUSHQ:           dste_o = RSP;
      I_POPQ: begin
        dste_o = RSP;
        dstm_o = ra_i;
      end
      I_MRMOVQ:                         dstm_o = ra_i;
      default: begin
        dste_o = RNONE;
        dstm_o = RNONE;
      end
    endcase
  end

  write_back_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .dste_i (dste_o),
    .dstm_i (dstm_o),
    .vale_i (vale_i),
    .valm_i (valm_i),
    .srca_i (srca_i),
    .srcb_i (srcb_i),
    .vala_o (vala_o),
    .valb_o (valb_o)
  );

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: vector table plus reset / bypass sequences.
module tb_write_back;
  import y86_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        icode, ra, rb, srca, srcb, dste, dstm;
  logic [DATA_W-1:0] vale, valm, vala, valb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  write_back dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .icode_i (icode),
    .ra_i    (ra),
    .rb_i    (rb),
    .vale_i  (vale),
    .valm_i  (valm),
    .srca_i  (srca),
    .srcb_i  (srcb),
    .vala_o  (vala),
    .valb_o  (valb),
    .dste_o  (dste),
    .dstm_o  (dstm)
  );

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] vale;
    logic [63:0] valm;
    logic [3:0]  exp_dste;
    logic [3:0]  exp_dstm;
    logic [3:0]  srca;
    logic [63:0] exp_a;
    logic [3:0]  srcb;
    logic [63:0] exp_b;
  } vec_t;

  localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'hFEDCBA9876543210;

  vec_t        vecs [15];
  logic [63:0] final_exp [15];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic [63:0] e, input logic [63:0] m);
    icode = ic; ra = a; rb = b; vale = e; valm = m;
  endtask

  initial begin
    //          icode ra    rb    valE      valM      dstE  dstM  srcA  expA      srcB  expB
    vecs[0]  = '{4'h2, 4'h1, 4'h2, K1,       K2,       4'h2, 4'hF, 4'h1, 64'h0,    4'h2, K1};
    vecs[1]  = '{4'h5, 4'h3, 4'h6, 64'h55,   K2,       4'hF, 4'h3, 4'h3, K2,       4'h6, 64'h0};
    vecs[2]  = '{4'hB, 4'h7, 4'hF, 64'h100,  64'hAA,   4'h4, 4'h7, 4'h4, 64'h100,  4'h7, 64'hAA};
    vecs[3]  = '{4'hB, 4'h4, 4'hF, 64'h200,  64'hBB,   4'h4, 4'h4, 4'h4, 64'hBB,   4'h7, 64'hAA};
    vecs[4]  = '{4'h0, 4'h1, 4'h2, 64'hDEAD, 64'hBEEF, 4'hF, 4'hF, 4'h1, 64'h0,    4'h2, K1};
    vecs[5]  = '{4'h1, 4'h3, 4'h3, 64'hDEAD, 64'hBEEF, 4'hF, 4'hF, 4'h3, K2,       4'h2, K1};
    vecs[6]  = '{4'h4, 4'h5, 4'h4, 64'hDEAD, 64'hBEEF, 4'hF, 4'hF, 4'h4, 64'hBB,   4'h5, 64'h0};
    vecs[7]  = '{4'h7, 4'h0, 4'h0, 64'h1,    64'h1,    4'hF, 4'hF, 4'h0, 64'h0,    4'hF, 64'h0};
    vecs[8]  = '{4'h2, 4'h1, 4'hF, 64'h77,   64'h88,   4'hF, 4'hF, 4'hF, 64'h0,    4'h1, 64'h0};
    vecs[9]  = '{4'h3, 4'hF, 4'h8, 64'h1234, 64'h9,    4'h8, 4'hF, 4'h8, 64'h1234, 4'h2, K1};
    vecs[10] = '{4'h6, 4'h1, 4'h9, 64'h99,   64'h0,    4'h9, 4'hF, 4'h9, 64'h99,   4'h1, 64'h0};
    vecs[11] = '{4'h8, 4'h1, 4'h1, 64'h300,  64'h5,    4'h4, 4'hF, 4'h4, 64'h300,  4'h7, 64'hAA};
    vecs[12] = '{4'hC, 4'h4, 4'h4, 64'hCC,   64'hCC,   4'hF, 4'hF, 4'h4, 64'h300,  4'h3, K2};
    vecs[13] = '{4'hF, 4'h4, 4'h4, 64'hDD,   64'hDD,   4'hF, 4'hF, 4'h4, 64'h300,  4'h1, 64'h0};
    vecs[14] = '{4'h9, 4'h2, 4'h2, 64'h400,  64'h6,    4'h4, 4'hF, 4'h4, 64'h400,  4'h2, K1};

    final_exp = '{64'h0, 64'h0, K1, K2, 64'h400, 64'h0, 64'h0, 64'hAA,
                  64'h1234, 64'h99, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};

    set_in(4'h1, 4'hF, 4'hF, '0, '0);
    srca = 4'h0; srcb = 4'h0;

    // Reset, then sweep every register on both ports.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      srca = 4'(i); srcb = 4'(14 - i);
      #1;
      chk($sformatf("reset_a_r%0d", i), vala, 64'h0);
      chk($sformatf("reset_b_r%0d", 14 - i), valb, 64'h0);
    end

    // Table: drive before edge, check decode, commit, check reads after edge.
    for (int v = 0; v < 15; v++) begin
      @(negedge clk);
      set_in(vecs[v].icode, vecs[v].ra, vecs[v].rb, vecs[v].vale, vecs[v].valm);
      #1;
      chk($sformatf("v%0d_dste", v), 64'(dste), 64'(vecs[v].exp_dste));
      chk($sformatf("v%0d_dstm", v), 64'(dstm), 64'(vecs[v].exp_dstm));
      @(posedge clk);
      #1;
      set_in(4'h1, 4'hF, 4'hF, '0, '0);
      srca = vecs[v].srca; srcb = vecs[v].srcb;
      #1;
      chk($sformatf("v%0d_vala", v), vala, vecs[v].exp_a);
      chk($sformatf("v%0d_valb", v), valb, vecs[v].exp_b);
    end

    // Full file state after the table.
    for (int i = 0; i < 15; i++) begin
      srca = 4'(i);
      #1;
      chk($sformatf("final_r%0d", i), vala, final_exp[i]);
    end

    // No bypass: old value readable before the edge, new value after.
    @(negedge clk);
    set_in(4'h3, 4'hF, 4'hA, 64'h5A5A, 64'h0);
    srca = 4'hA;
    #1 chk("nobypass_before", vala, 64'h0);
    @(posedge clk);
    #1 chk("nobypass_after", vala, 64'h5A5A);

    // Async reset between edges clears immediately and blocks writes.
    set_in(4'h3, 4'hF, 4'h2, 64'hFFFF, 64'h0);
    srca = 4'h2; srcb = 4'hA;
    #2 chk("pre_reset_r2", vala, K1);
    rst_n = 1'b0;
    #1;
    chk("async_r2", vala, 64'h0);
    chk("async_ra", valb, 64'h0);
    @(posedge clk);
    #1 chk("held_r2", vala, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("released_r2", vala, 64'h0);
    @(posedge clk);
    #1 chk("resume_r2", vala, 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
